// File: rtl/vga_timing_gen.sv
// VGA raster engine: pixel-tick divider, h/v scan counters, sync/blank generation and registered colour.
// Define VGA_VBLANK_IRQ_EN to build the start-of-vblank interrupt; otherwise irq is tied low.
module vga_timing_gen #(
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter int   CLK_DIV  = 2,
   parameter int   COLOR_W  = 1,
   parameter logic HS_POL   = 1'b0,
   parameter logic VS_POL   = 1'b0,
   parameter int   CNT_W    = 11
) (
   input  logic               clk_50mhz,
   input  logic               rst,
   input  logic               en,
   input  logic [COLOR_W-1:0] pix_r,
   input  logic [COLOR_W-1:0] pix_g,
   input  logic [COLOR_W-1:0] pix_b,
   input  logic               irq_ack,
   output logic [CNT_W-1:0]   x,
   output logic [CNT_W-1:0]   y,
   output logic               pix_req,
   output logic [COLOR_W-1:0] vga_red,
   output logic [COLOR_W-1:0] vga_green,
   output logic [COLOR_W-1:0] vga_blue,
   output logic               vga_hsync,
   output logic               vga_vsync,
   output logic               de,
   output logic               frame_start,
   output logic               irq
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CNT_W-1:0] V_BLANK0 = CNT_W'(V_ACTIVE - 1);

   logic [DIV_W-1:0]   div_q, div_d;
   logic [CNT_W-1:0]   h_q, h_d;
   logic [CNT_W-1:0]   v_q, v_d;
   logic               tick, h_wrap, v_wrap, active, hs_raw, vs_raw;
   logic [COLOR_W-1:0] red_q, green_q, blue_q;
   logic               hs_q, vs_q, de_q;

   assign tick   = en && (div_q == DIV_LAST);
   assign h_wrap = (h_q == H_LAST);
   assign v_wrap = (v_q == V_LAST);
   assign active = (h_q < H_ACT) && (v_q < V_ACT);
   assign hs_raw = (h_q >= HS_START) && (h_q < HS_END);
   assign vs_raw = (v_q >= VS_START) && (v_q < VS_END);

   always_comb begin
      div_d = div_q;
      h_d   = h_q;
      v_d   = v_q;
      if (en) begin
         div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      end
      if (tick) begin
         if (h_wrap) begin
            h_d = '0;
            v_d = v_wrap ? '0 : v_q + 1'b1;
         end else begin
            h_d = h_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_50mhz or negedge rst) begin
      if (!rst) begin
         div_q <= '0;
         h_q   <= '0;
         v_q   <= '0;
      end else begin
         div_q <= div_d;
         h_q   <= h_d;
         v_q   <= v_d;
      end
   end

   // Output stage renders the position that was current at the tick, so pins lag counters by one pixel.
   always_ff @(posedge clk_50mhz or negedge rst) begin
      if (!rst) begin
         red_q   <= '0;
         green_q <= '0;
         blue_q  <= '0;
         de_q    <= 1'b0;
         hs_q    <= ~HS_POL;
         vs_q    <= ~VS_POL;
      end else if (!en) begin
         red_q   <= '0;
         green_q <= '0;
         blue_q  <= '0;
         de_q    <= 1'b0;
         hs_q    <= ~HS_POL;
         vs_q    <= ~VS_POL;
      end else if (tick) begin
         red_q   <= active ? pix_r : '0;
         green_q <= active ? pix_g : '0;
         blue_q  <= active ? pix_b : '0;
         de_q    <= active;
         hs_q    <= hs_raw ? HS_POL : ~HS_POL;
         vs_q    <= vs_raw ? VS_POL : ~VS_POL;
      end
   end

   // Strobes are combinational from registered state; gating with rst keeps them low during reset.
   assign pix_req     = rst && tick && active;
   assign frame_start = rst && tick && h_wrap && v_wrap;

   assign x         = h_q;
   assign y         = v_q;
   assign vga_red   = red_q;
   assign vga_green = green_q;
   assign vga_blue  = blue_q;
   assign vga_hsync = hs_q;
   assign vga_vsync = vs_q;
   assign de        = de_q;

`ifdef VGA_VBLANK_IRQ_EN
   logic irq_q;

   always_ff @(posedge clk_50mhz or negedge rst) begin
      if (!rst) begin
         irq_q <= 1'b0;
      end else if (tick && h_wrap && (v_q == V_BLANK0)) begin
         irq_q <= 1'b1;
      end else if (irq_ack) begin
         irq_q <= 1'b0;
      end
   end

   assign irq = irq_q;
`else
   logic unused_irq_ack;
   assign unused_irq_ack = irq_ack;
   assign irq            = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen in a small mode (H 8/1/2/1, V 4/1/1/1, CLK_DIV 2, COLOR_W 4, HS_POL 1).
module tb_vga_timing_gen;
   localparam int HT = 12;
   localparam int VT = 7;
   localparam int FRAME_CLKS = HT * VT * 2;
`ifdef VGA_VBLANK_IRQ_EN
   localparam int IRQ_ON = 1;
`else
   localparam int IRQ_ON = 0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b1;
   logic       irq_ack = 1'b0;
   logic [3:0] pix_r, pix_g, pix_b;
   logic [3:0] x, y;
   logic       pix_req, vga_hsync, vga_vsync, de, frame_start, irq;
   logic [3:0] vga_red, vga_green, vga_blue;

   int   vectors = 0;
   int   miscompares = 0;
   int   e = 0;
   logic forced = 1'b0;
   logic exp_irq = 1'b0;

   always #5 clk = ~clk;

   // Renderer stand-in: red carries the requested column, green the row, blue a constant.
   assign pix_r = x;
   assign pix_g = y;
   assign pix_b = 4'hA;

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .CLK_DIV(2), .COLOR_W(4), .HS_POL(1'b1), .VS_POL(1'b0), .CNT_W(4)
   ) dut (
      .clk_50mhz(clk), .rst(rst), .en(en),
      .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .irq_ack(irq_ack),
      .x(x), .y(y), .pix_req(pix_req),
      .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
      .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .de(de),
      .frame_start(frame_start), .irq(irq)
   );

   task automatic chk(input string tag, input int obs, input int exp_v);
      vectors++;
      if (obs !== exp_v) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (e=%0d t=%0t)", tag, obs, exp_v, e, $time);
      end
   endtask

   // Expected values derive from the enabled-edge count e: pixel tick k = e/2, position k mod (HT,VT).
   task automatic check_all();
      int k, ph, hx, vy, q, hq, vq;
      int er, eg, eb, ede, ehs, evs;
      bit act, qa;
      k  = e / 2;
      ph = e % 2;
      hx = k % HT;
      vy = (k / HT) % VT;
      act = (hx < 8) && (vy < 4);
      chk("x", x, hx);
      chk("y", y, vy);
      chk("pix_req", pix_req, int'(en && ph == 1 && act));
      chk("frame_start", frame_start, int'(en && ph == 1 && hx == 11 && vy == 6));
      if (forced || k == 0) begin
         er = 0; eg = 0; eb = 0; ede = 0; ehs = 0; evs = 1;
      end else begin
         q  = k - 1;
         hq = q % HT;
         vq = (q / HT) % VT;
         qa = (hq < 8) && (vq < 4);
         er  = qa ? hq : 0;
         eg  = qa ? vq : 0;
         eb  = qa ? 10 : 0;
         ede = int'(qa);
         ehs = (hq >= 9 && hq < 11) ? 1 : 0;
         evs = (vq == 5) ? 0 : 1;
      end
      chk("vga_red", vga_red, er);
      chk("vga_green", vga_green, eg);
      chk("vga_blue", vga_blue, eb);
      chk("de", de, ede);
      chk("vga_hsync", vga_hsync, ehs);
      chk("vga_vsync", vga_vsync, evs);
      chk("irq", irq, int'(exp_irq));
      $display("e=%0d en=%0d x=%0d y=%0d req=%0d rgb=%0d/%0d/%0d de=%0d hs=%0d vs=%0d fs=%0d irq=%0d",
               e, en, x, y, pix_req, vga_red, vga_green, vga_blue, de, vga_hsync, vga_vsync,
               frame_start, irq);
   endtask

   task automatic step();
      bit set;
      @(posedge clk);
      set = 1'b0;
      if (en) begin
         e++;
         if (e % 2 == 0) begin
            forced = 1'b0;
            set = (IRQ_ON == 1) && ((e / 2) % (HT * VT) == 48);
         end
      end else begin
         forced = 1'b1;
      end
      if (set) exp_irq = 1'b1;
      else if (irq_ack) exp_irq = 1'b0;
      @(negedge clk);
      check_all();
   endtask

   task automatic run_until(input int target);
      int n;
      n = 0;
      while ((e % FRAME_CLKS) != target && n < 400) begin
         step();
         n++;
      end
      if (n >= 400) chk("run_until_timeout", 0, 1);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_all();
      rst = 1'b1;
      step();
      chk("div_no_tick_x", x, 0);
      step();
      chk("first_tick_x", x, 1);
      repeat (344) step();

      irq_ack = 1'b1;
      step();
      irq_ack = 1'b0;
      chk("irq_after_ack", irq, 0);

      run_until(95);
      irq_ack = 1'b1;
      step();
      irq_ack = 1'b0;
      chk("irq_set_wins", irq, IRQ_ON);
      irq_ack = 1'b1;
      step();
      irq_ack = 1'b0;
      chk("irq_plain_ack", irq, 0);

      run_until(10);
      chk("pre_freeze_de", de, 1);
      en = 1'b0;
      repeat (10) step();
      chk("freeze_x", x, 5);
      chk("freeze_de", de, 0);
      en = 1'b1;
      step();
      chk("resume_hold_x", x, 5);
      step();
      chk("resume_x", x, 6);

      run_until(22);
      chk("pre_freeze_hsync", vga_hsync, 1);
      en = 1'b0;
      step();
      chk("freeze_hsync", vga_hsync, 0);
      repeat (4) step();
      en = 1'b1;

      run_until(124);
      chk("pre_freeze_vsync", vga_vsync, 0);
      en = 1'b0;
      step();
      chk("freeze_vsync", vga_vsync, 1);
      en = 1'b1;
      repeat (6) step();

      // Asynchronous mid-frame reset, checked between clock edges.
      rst = 1'b0;
      e = 0;
      forced = 1'b0;
      exp_irq = 1'b0;
      #1;
      check_all();
      repeat (10) begin
         @(negedge clk);
         check_all();
      end
      rst = 1'b1;
      step();
      step();
      chk("reset_first_tick_x", x, 1);
      repeat (40) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
